decompose_ctrl: RTL and testbench



---
 rtl/dilithium_pkg.sv | 25 ++
 rtl/decomp_map1.sv | 24 ++
 rtl/decompose_ctrl.sv | 135 +++++++++++++
 tb/tb_decompose_ctrl.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dilithium_pkg.sv
// Shared constants and FSM encoding for the Dilithium decompose datapath.
package dilithium_pkg;

  localparam int Q         = 8380417;
  localparam int GAMMA2_88 = 95232;
  localparam int GAMMA2_32 = 261888;
  localparam int M_88      = 44;
  localparam int M_32      = 16;
  localparam int N_COEF    = 256;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  function automatic logic [18:0] gamma2_of(input logic [2:0] sec);
    return (sec == 3'd2) ? 19'(GAMMA2_88) : 19'(GAMMA2_32);
  endfunction

  function automatic logic [5:0] m_of(input logic [2:0] sec);
    return (sec == 3'd2) ? 6'(M_88) : 6'(M_32);
  endfunction

endpackage

// File: rtl/decomp_map1.sv
// High-bits map: counts rounding thresholds met by din, folding the
// top interval (din >= q - gamma2) back to zero.
module decomp_map1
  import dilithium_pkg::*;
(
  input  logic [2:0]  sec_lvl,
  input  logic [22:0] din,
  output logic [5:0]  dout
);

  logic [18:0] g;

  always_comb begin
    g    = gamma2_of(sec_lvl);
    dout = '0;
    for (int k = 1; k < M_88; k++) begin
      if (int'(din) >= k * 2 * int'(g) - int'(g) + 1)
        dout = dout + 6'd1;
    end
    if (int'(din) >= Q - int'(g))
      dout = '0;
  end

endmodule

// File: rtl/decompose_ctrl.sv
// Streaming decompose of one polynomial: FSM, counters, 2-stage pipe.
// Optional DECOMPOSE_USEHINT_EN adds hint_i and the use-hint r1 fix-up.
module decompose_ctrl
  import dilithium_pkg::*;
#(
  parameter int N     = 256,
  parameter int CNT_W = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  sec_lvl,
  input  logic        start,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [22:0] data_i,
`ifdef DECOMPOSE_USEHINT_EN
  input  logic        hint_i,
`endif
  output logic        valid_o,
  input  logic        ready_i,
  output logic [5:0]  r1_o,
  output logic [18:0] r0_o,
  output logic        last_o,
  output logic        busy,
  output logic        done
);

  state_t state, state_n;

  logic [2:0]       sec_q;
  logic [CNT_W-1:0] in_cnt, out_cnt;
  logic             v1, v2, done_q;
  logic [5:0]       s1_r1, map_r1, r1_fix;
  logic [22:0]      s1_data;
  logic [18:0]      g2, sub, r0_w;
  logic             wrap, adv, in_xfer, out_xfer, start_ok;
`ifdef DECOMPOSE_USEHINT_EN
  logic             s1_hint;
  logic [5:0]       m;
`endif

  decomp_map1 u_map (
    .sec_lvl (sec_q),
    .din     (data_i),
    .dout    (map_r1)
  );

  // One advance signal moves both stages, so a stall never splits them
  assign adv      = !v2 || ready_i;
  assign ready_o  = (state == ST_RUN) && (in_cnt < CNT_W'(N)) && adv;
  assign in_xfer  = valid_i && ready_o;
  assign valid_o  = v2;
  assign out_xfer = v2 && ready_i;
  assign last_o   = v2 && (out_cnt == CNT_W'(N - 1));
  assign busy     = (state != ST_IDLE);
  assign done     = done_q;
  assign start_ok = (state == ST_IDLE) && start;

  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE:  if (start) state_n = ST_RUN;
      ST_RUN:   if (in_xfer && in_cnt == CNT_W'(N - 1)) state_n = ST_DRAIN;
      ST_DRAIN: if (out_xfer && last_o) state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  // r0 is computed mod 2^19; the true value lies in [-gamma2, gamma2]
  always_comb begin
    g2     = gamma2_of(sec_q);
    wrap   = s1_data >= (23'(Q) - 23'(g2));
    sub    = wrap ? 19'(Q) : 19'(25'(s1_r1) * 25'({g2, 1'b0}));
    r0_w   = 19'(s1_data) - sub;
    r1_fix = s1_r1;
`ifdef DECOMPOSE_USEHINT_EN
    m = m_of(sec_q);
    if (s1_hint) begin
      if (!r0_w[18] && r0_w != '0)
        r1_fix = (s1_r1 == m - 6'd1) ? '0 : s1_r1 + 6'd1;
      else
        r1_fix = (s1_r1 == '0) ? m - 6'd1 : s1_r1 - 6'd1;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sec_q   <= '0;
      in_cnt  <= '0;
      out_cnt <= '0;
      v1      <= 1'b0;
      v2      <= 1'b0;
      done_q  <= 1'b0;
      s1_r1   <= '0;
      s1_data <= '0;
      r1_o    <= '0;
      r0_o    <= '0;
`ifdef DECOMPOSE_USEHINT_EN
      s1_hint <= 1'b0;
`endif
    end else begin
      done_q <= (state == ST_DRAIN) && out_xfer && last_o;
      if (start_ok) begin
        sec_q   <= sec_lvl;
        in_cnt  <= '0;
        out_cnt <= '0;
      end else begin
        if (in_xfer)  in_cnt  <= in_cnt + CNT_W'(1);
        if (out_xfer) out_cnt <= out_cnt + CNT_W'(1);
      end
      if (adv) begin
        v1 <= in_xfer;
        v2 <= v1;
        if (in_xfer) begin
          s1_r1   <= map_r1;
          s1_data <= data_i;
`ifdef DECOMPOSE_USEHINT_EN
          s1_hint <= hint_i;
`endif
        end
        if (v1) begin
          r1_o <= r1_fix;
          r0_o <= r0_w;
        end
      end
    end
  end

endmodule

// File: tb/tb_decompose_ctrl.sv
// Directed bench for decompose_ctrl: vectors, full polys, stall, reset.
// Build with DECOMPOSE_USEHINT_EN to include the hint scenario.
module tb_decompose_ctrl;

  localparam int QQ = 8380417;
  localparam int NN = 256;

  logic        clk, rst, start, valid_i, ready_o, valid_o, ready_i;
  logic        last_o, busy, done;
  logic [2:0]  sec_lvl;
  logic [22:0] data_i;
  logic [5:0]  r1_o;
  logic [18:0] r0_o;
`ifdef DECOMPOSE_USEHINT_EN
  logic        hint_i;
  bit          stream_h[NN];
`endif

  int n_cmp, n_err;
  int stream_d[NN];
  int got_r1[NN];
  int got_r0[NN];
  bit got_last[NN];
  int out_n, in_n, first_acc, first_val, last_cyc, done_cyc, done_n;
  int hold_bad, ready_drop, timeout, busy_at_done, done_after;

  decompose_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .sec_lvl (sec_lvl),
    .start   (start),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_i  (data_i),
`ifdef DECOMPOSE_USEHINT_EN
    .hint_i  (hint_i),
`endif
    .valid_o (valid_o),
    .ready_i (ready_i),
    .r1_o    (r1_o),
    .r0_o    (r0_o),
    .last_o  (last_o),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic void ref_dec(input int sec, input int a,
                                  output int r1, output int r0);
    int g;
    g  = (sec == 2) ? 95232 : 261888;
    r1 = (a + g - 1) / (2 * g);
    r0 = a - r1 * 2 * g;
    if (a >= QQ - g) begin
      r1 = 0;
      r0 = a - QQ;
    end
  endfunction

  function automatic int count_bad(input int sec, output int first);
    int e1, e0, n;
    n = 0;
    first = -1;
    for (int i = 0; i < NN; i++) begin
      ref_dec(sec, stream_d[i], e1, e0);
      if (got_r1[i] != e1 || got_r0[i] != e0) begin
        n++;
        if (first < 0) first = i;
      end
    end
    return n;
  endfunction

  task automatic fill(input int seed);
    for (int i = 0; i < NN; i++) begin
      stream_d[i] = (i * 32771 + seed) % QQ;
`ifdef DECOMPOSE_USEHINT_EN
      stream_h[i] = 1'b0;
`endif
    end
    stream_d[7] = QQ - 1;
    stream_d[8] = 0;
  endtask

  // Drives one polynomial and records what comes out; no checks here
  task automatic run_poly(input logic [2:0] sec, input int stall_at,
                          input int stall_len);
    int cyc, rem, idx;
    bit stalled, pv, pr, pl;
    logic [5:0]  p1;
    logic [18:0] p0;
    out_n = 0; in_n = 0; first_acc = -1; first_val = -1;
    last_cyc = -1; done_cyc = -1; done_n = 0; hold_bad = 0;
    ready_drop = 0; busy_at_done = -1; done_after = -1;
    rem = 0; stalled = 0; pv = 0; pr = 1; pl = 0; p1 = '0; p0 = '0;
    for (int i = 0; i < NN; i++) begin
      got_r1[i] = -999; got_r0[i] = -999; got_last[i] = 0;
    end
    sec_lvl = sec;
    start = 1'b1;
    tick();
    start = 1'b0;
    sec_lvl = (sec == 3'd2) ? 3'd3 : 3'd2;
    cyc = 0;
    while (done_cyc < 0 && cyc < 3000) begin
      start = (cyc == 50);
      idx = (in_n < NN) ? in_n : 0;
      valid_i = (in_n < NN);
      data_i = 23'(stream_d[idx]);
`ifdef DECOMPOSE_USEHINT_EN
      hint_i = stream_h[idx];
`endif
      if (!stalled && stall_len > 0 && out_n == stall_at - 1) begin
        stalled = 1;
        rem = stall_len;
      end
      ready_i = (rem == 0);
      #1;
      if (pv && !pr)
        if (valid_o !== pv || r1_o !== p1 || r0_o !== p0 || last_o !== pl)
          hold_bad++;
      if (rem > 0 && ready_o === 1'b0) ready_drop++;
      if (done === 1'b1) begin
        done_n++;
        done_cyc = cyc;
        busy_at_done = int'(busy);
      end
      if (valid_i && ready_o === 1'b1) begin
        if (first_acc < 0) first_acc = cyc;
        in_n++;
      end
      if (valid_o === 1'b1 && first_val < 0) first_val = cyc;
      if (valid_o === 1'b1 && ready_i) begin
        if (out_n < NN) begin
          got_r1[out_n] = int'(r1_o);
          got_r0[out_n] = int'($signed(r0_o));
          got_last[out_n] = last_o;
        end
        if (last_o === 1'b1) last_cyc = cyc;
        out_n++;
      end
      pv = valid_o; pr = ready_i; p1 = r1_o; p0 = r0_o; pl = last_o;
      if (rem > 0) rem--;
      cyc++;
      tick();
    end
    start = 1'b0;
    timeout = (done_cyc < 0);
    done_after = int'(done);
    valid_i = 1'b0;
    ready_i = 1'b1;
  endtask

  task automatic test_reset;
    n_cmp++;
    if ({valid_o, ready_o, last_o, busy, done} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_flags: got %b expected 00000",
               {valid_o, ready_o, last_o, busy, done});
    end
    n_cmp++;
    if ({r1_o, r0_o} !== 25'b0) begin
      n_err++;
      $display("FAIL reset_data: got r1=%0d r0=%0d expected 0 0", r1_o, r0_o);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_sec2_vectors;
    int e1[3] = '{0, 1, 0};
    int e0[3] = '{0, -95231, -95232};
    fill(111);
    stream_d[0] = 0; stream_d[1] = 95233; stream_d[2] = 8285185;
    run_poly(3'd2, 0, 0);
    n_cmp++;
    if (timeout != 0) begin
      n_err++;
      $display("FAIL sec2_timeout: got %0d expected 0", timeout);
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (got_r1[i] != e1[i]) begin
        n_err++;
        $display("FAIL sec2_r1[%0d]: got %0d expected %0d", i, got_r1[i], e1[i]);
      end
      n_cmp++;
      if (got_r0[i] != e0[i]) begin
        n_err++;
        $display("FAIL sec2_r0[%0d]: got %0d expected %0d", i, got_r0[i], e0[i]);
      end
    end
  endtask

  task automatic test_sec3_vectors;
    int e1[3] = '{0, 1, 0};
    int e0[3] = '{261888, -261887, -1};
    fill(222);
    stream_d[0] = 261888; stream_d[1] = 261889; stream_d[2] = 8380416;
    run_poly(3'd3, 0, 0);
    n_cmp++;
    if (timeout != 0) begin
      n_err++;
      $display("FAIL sec3_timeout: got %0d expected 0", timeout);
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (got_r1[i] != e1[i]) begin
        n_err++;
        $display("FAIL sec3_r1[%0d]: got %0d expected %0d", i, got_r1[i], e1[i]);
      end
      n_cmp++;
      if (got_r0[i] != e0[i]) begin
        n_err++;
        $display("FAIL sec3_r0[%0d]: got %0d expected %0d", i, got_r0[i], e0[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int bad, first, nlast, lidx;
    fill(12345);
    run_poly(3'd2, 0, 0);
    bad = count_bad(2, first);
    nlast = 0; lidx = -1;
    for (int i = 0; i < NN; i++)
      if (got_last[i]) begin nlast++; lidx = i; end
    n_cmp++;
    if (timeout != 0 || out_n != NN) begin
      n_err++;
      $display("FAIL b2b_count: got %0d results (timeout %0d) expected %0d",
               out_n, timeout, NN);
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL b2b_data: got %0d bad (first %0d) expected 0", bad, first);
    end
    n_cmp++;
    if (first_val - first_acc != 2) begin
      n_err++;
      $display("FAIL b2b_latency: got %0d expected 2", first_val - first_acc);
    end
    n_cmp++;
    if (nlast != 1 || lidx != NN - 1) begin
      n_err++;
      $display("FAIL b2b_last: got %0d flags at %0d expected 1 at 255",
               nlast, lidx);
    end
    n_cmp++;
    if (done_cyc != last_cyc + 1) begin
      n_err++;
      $display("FAIL b2b_done_time: got %0d expected %0d", done_cyc, last_cyc + 1);
    end
    n_cmp++;
    if (busy_at_done != 0 || done_after != 0) begin
      n_err++;
      $display("FAIL b2b_after: got busy=%0d done_next=%0d expected 0 0",
               busy_at_done, done_after);
    end
    // full-rate throughput: 256 accepts in 256 consecutive cycles
    n_cmp++;
    if (last_cyc - first_val != NN - 1) begin
      n_err++;
      $display("FAIL b2b_rate: got %0d expected %0d", last_cyc - first_val, NN - 1);
    end
  endtask

  task automatic test_backpressure;
    int bad, first;
    fill(777);
    run_poly(3'd3, 40, 5);
    bad = count_bad(3, first);
    n_cmp++;
    if (timeout != 0 || out_n != NN) begin
      n_err++;
      $display("FAIL bp_count: got %0d results (timeout %0d) expected %0d",
               out_n, timeout, NN);
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL bp_data: got %0d bad (first %0d) expected 0", bad, first);
    end
    n_cmp++;
    if (hold_bad != 0) begin
      n_err++;
      $display("FAIL bp_hold: got %0d unstable cycles expected 0", hold_bad);
    end
    n_cmp++;
    if (ready_drop != 5) begin
      n_err++;
      $display("FAIL bp_ready_drop: got %0d expected 5", ready_drop);
    end
    n_cmp++;
    if (done_n != 1 || done_after != 0) begin
      n_err++;
      $display("FAIL bp_done: got %0d pulses next=%0d expected 1 0",
               done_n, done_after);
    end
  endtask

  task automatic test_reset_mid;
    int n, c, seen, bad, first;
    fill(4242);
    sec_lvl = 3'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    valid_i = 1'b1;
    ready_i = 1'b1;
    n = 0; c = 0;
    while (n < 100 && c < 1000) begin
      data_i = 23'(stream_d[n]);
      #1;
      if (ready_o === 1'b1) n++;
      tick();
      c++;
    end
    valid_i = 1'b0;
    n_cmp++;
    if (n != 100) begin
      n_err++;
      $display("FAIL mid_feed: got %0d accepted expected 100", n);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({valid_o, ready_o, last_o, busy, done} !== 5'b0 ||
        {r1_o, r0_o} !== 25'b0) begin
      n_err++;
      $display("FAIL mid_reset: got flags %b r1=%0d r0=%0d expected all 0",
               {valid_o, ready_o, last_o, busy, done}, r1_o, r0_o);
    end
    tick();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (done === 1'b1 || valid_o === 1'b1 || busy === 1'b1) seen++;
      tick();
    end
    n_cmp++;
    if (seen != 0) begin
      n_err++;
      $display("FAIL mid_quiet: got %0d active cycles expected 0", seen);
    end
    run_poly(3'd2, 0, 0);
    bad = count_bad(2, first);
    n_cmp++;
    if (timeout != 0 || out_n != NN || bad != 0) begin
      n_err++;
      $display("FAIL mid_restart: got %0d results %0d bad expected %0d 0",
               out_n, bad, NN);
    end
  endtask

`ifdef DECOMPOSE_USEHINT_EN
  task automatic test_hint;
    fill(55);
    stream_d[0] = 0;     stream_h[0] = 1'b1;
    stream_d[1] = 95233; stream_h[1] = 1'b1;
    run_poly(3'd2, 0, 0);
    n_cmp++;
    if (got_r1[0] != 43 || got_r0[0] != 0) begin
      n_err++;
      $display("FAIL hint_sec2_zero: got r1=%0d r0=%0d expected 43 0",
               got_r1[0], got_r0[0]);
    end
    n_cmp++;
    if (got_r1[1] != 0 || got_r0[1] != -95231) begin
      n_err++;
      $display("FAIL hint_sec2_one: got r1=%0d r0=%0d expected 0 -95231",
               got_r1[1], got_r0[1]);
    end
    fill(66);
    stream_d[0] = 8118528; stream_h[0] = 1'b1;
    run_poly(3'd5, 0, 0);
    n_cmp++;
    if (got_r1[0] != 0 || got_r0[0] != 261888) begin
      n_err++;
      $display("FAIL hint_sec5_wrap: got r1=%0d r0=%0d expected 0 261888",
               got_r1[0], got_r0[0]);
    end
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    start = 1'b0;
    sec_lvl = '0;
    valid_i = 1'b0;
    data_i = '0;
    ready_i = 1'b1;
`ifdef DECOMPOSE_USEHINT_EN
    hint_i = 1'b0;
`endif
    #12;
    test_reset();
    test_sec2_vectors();
    test_sec3_vectors();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
`ifdef DECOMPOSE_USEHINT_EN
    test_hint();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
